// File: rtl/ysyx_23060096_idu_ctrl.sv
// ysyx_23060096_idu_ctrl: decode-stage pipeline register between IFU and EXU with imm-gen control
// Ports: in_valid/in_ready/in_inst/in_pc  IFU side handshake and payload
//        out_valid/out_ready/out_inst/out_pc  EXU side handshake and held payload
//        ext_op/imm_inst/imm_used  immediate generator controls, illegal/trap_ack  exception path
//        flush  drops the held instruction, stall_cnt  saturating back-pressure cycle count
module ysyx_23060096_idu_ctrl #(
  parameter int CNT_W        = 16,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  output logic [2:0]       ext_op,
  output logic [24:0]      imm_inst,
  output logic             imm_used,
  output logic             illegal,
  input  logic             trap_ack,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {IDLE, FULL, TRAP} state_t;
  state_t state_q, state_d;
  logic [31:0] inst_q, pc_q;
  logic [2:0] ext_q, ext_d;
  logic used_q, used_d, ill_q, ill_d, legal, accept;
  logic [CNT_W-1:0] cnt_q;
  assign in_ready  = !flush && (state_q == IDLE || (state_q == FULL && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = state_q == FULL;
  assign out_inst  = inst_q;
  assign out_pc    = pc_q;
  assign imm_inst  = inst_q[31:7];
  assign ext_op    = ext_q;
  assign imm_used  = used_q;
  assign illegal   = ill_q;
  assign stall_cnt = cnt_q;
  always_comb begin
    ext_d  = 3'b000;
    used_d = 1'b1;
    legal  = 1'b1;
    case (in_inst[6:0])
      7'b0110111, 7'b0010111: ext_d = 3'b001;
      7'b1101111: ext_d = 3'b100;
      7'b1100011: ext_d = 3'b011;
      7'b0100011: ext_d = 3'b010;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: ext_d = 3'b000;
      7'b0110011: used_d = 1'b0;
      default: begin
        used_d = 1'b0;
        legal  = 1'b0;
      end
    endcase
  end
  // illegal is a one-cycle pulse after accept, except it is held for the whole TRAP stay
  always_comb begin
    state_d = state_q;
    ill_d   = 1'b0;
    if (state_q == TRAP) begin
      state_d = trap_ack ? IDLE : TRAP;
      ill_d   = !trap_ack;
    end else if (flush) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = (!legal && ILLEGAL_TRAP) ? TRAP : FULL;
      ill_d   = !legal;
    end else if (state_q == FULL && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      inst_q  <= '0;
      pc_q    <= '0;
      ext_q   <= '0;
      used_q  <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ill_q   <= ill_d;
      if (accept) begin
        inst_q <= in_inst;
        pc_q   <= in_pc;
        ext_q  <= ext_d;
        used_q <= used_d;
      end
      if (state_q == FULL && !out_ready && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule
